// File: rtl/class_arbiter_pkg.sv
// Shared definitions for the class arbiter: link state encodings, class count
// and where the class tag sits inside a data word.
package class_arbiter_pkg;

  // state     | meaning
  // ST_RESET  | link held in reset, arbiter clears like a hard reset
  // ST_INIT   | link training, no new pops, in-flight words drain
  // ST_IDLE   | link up, arbitration enabled
  // ST_ACTIVE | link up and carrying traffic, arbitration enabled
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } link_state_e;

  localparam int NUM_CLASS   = 4;
  localparam int CLASS_IDX_W = $clog2(NUM_CLASS);

  // The class tag occupies the top CLASS_W bits of every word.
  localparam int CLASS_W = 2;

  function automatic int class_msb(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int class_lsb(input int data_width);
    return data_width - CLASS_W;
  endfunction

endpackage

// File: rtl/class_arbiter_if.sv
// Bundle of the class FIFO read side, output FIFO write side and link state
// seen by the class arbiter. The arbiter uses the slave view.
interface class_arbiter_if #(
  parameter int DATA_WIDTH = 12
);
  logic [3:0]            state;
  logic [DATA_WIDTH-1:0] data_0;
  logic [DATA_WIDTH-1:0] data_1;
  logic [DATA_WIDTH-1:0] data_2;
  logic [DATA_WIDTH-1:0] data_3;
  logic                  empty_0;
  logic                  empty_1;
  logic                  empty_2;
  logic                  empty_3;
  logic                  almost_full_out;
  logic                  pop_0;
  logic                  pop_1;
  logic                  pop_2;
  logic                  pop_3;
  logic                  push_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  idle;

  modport slave (
    input  state,
    input  data_0, data_1, data_2, data_3,
    input  empty_0, empty_1, empty_2, empty_3,
    input  almost_full_out,
    output pop_0, pop_1, pop_2, pop_3,
    output push_out,
    output data_out,
    output idle
  );

  modport master (
    output state,
    output data_0, data_1, data_2, data_3,
    output empty_0, empty_1, empty_2, empty_3,
    output almost_full_out,
    input  pop_0, pop_1, pop_2, pop_3,
    input  push_out,
    input  data_out,
    input  idle
  );

endinterface

// File: rtl/class_arbiter_rr_pick.sv
// Rotating-priority picker: starting at i_ptr and walking upward modulo
// NUM_CLASS, grant the first requesting class (one-hot).
module class_arbiter_rr_pick
  import class_arbiter_pkg::*;
(
  input  logic [NUM_CLASS-1:0]   i_req,
  input  logic [CLASS_IDX_W-1:0] i_ptr,
  output logic [NUM_CLASS-1:0]   o_grant,
  output logic                   o_valid
);

  logic [CLASS_IDX_W-1:0] w_idx;

  // first requester at or after the pointer wins
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NUM_CLASS; off++) begin
      w_idx = i_ptr + off[CLASS_IDX_W-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/class_arbiter.sv
// Round-robin arbiter moving words from four class FIFOs into one output
// FIFO. Pops are combinational in the grant cycle; the popped word is
// captured the next cycle and pushed the cycle after that.
module class_arbiter
  import class_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input logic            clk,
  input logic            reset,
  class_arbiter_if.slave bus
);

  typedef logic [CLASS_IDX_W-1:0] cls_idx_t;

  logic [NUM_CLASS-1:0]  w_empty;
  logic [NUM_CLASS-1:0]  w_req;
  logic [NUM_CLASS-1:0]  w_grant;
  logic [NUM_CLASS-1:0]  w_pop;
  logic [DATA_WIDTH-1:0] w_data [NUM_CLASS];
  logic                  w_en;
  logic                  w_sync_clr;
  logic                  w_any;
  logic                  w_fire;
  cls_idx_t              w_grant_idx;

  cls_idx_t              r_rr_ptr;
  logic                  r_run;
  logic                  r_v1;
  cls_idx_t              r_sel1;
  logic                  r_v2;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_idle;

  assign w_empty   = {bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};
  assign w_data[0] = bus.data_0;
  assign w_data[1] = bus.data_1;
  assign w_data[2] = bus.data_2;
  assign w_data[3] = bus.data_3;

  assign w_sync_clr = (bus.state == ST_RESET);
  assign w_en       = (bus.state == ST_IDLE) || (bus.state == ST_ACTIVE);

  // A class popped last cycle is skipped: its empty flag may not yet reflect
  // that pop, so popping it again could underflow the FIFO.
  always_comb begin
    w_req = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      w_req[k] = ~w_empty[k] & ~(r_v1 && (r_sel1 == k[CLASS_IDX_W-1:0]));
    end
  end

  class_arbiter_rr_pick u_rr_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_valid (w_any)
  );

  // one-hot grant to class index
  always_comb begin
    w_grant_idx = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (w_grant[k]) begin
        w_grant_idx = k[CLASS_IDX_W-1:0];
      end
    end
  end

  // r_run keeps pops low while reset is held (and the first cycle after
  // release) without feeding the async reset into combinational logic.
  assign w_fire = w_en & r_run & ~bus.almost_full_out & w_any;
  assign w_pop  = w_fire ? w_grant : '0;

  assign bus.pop_0    = w_pop[0];
  assign bus.pop_1    = w_pop[1];
  assign bus.pop_2    = w_pop[2];
  assign bus.pop_3    = w_pop[3];
  assign bus.push_out = r_v2;
  assign bus.data_out = r_data_out;
  assign bus.idle     = r_idle;

  // arms pop issue once reset has been released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // round-robin pointer moves just past each granted class
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_sync_clr) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= w_grant_idx + cls_idx_t'(1);
    end
  end

  // two-stage valid/class-select pipeline tracking pops in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_sel1 <= '0;
      r_v2   <= 1'b0;
    end else if (w_sync_clr) begin
      r_v1   <= 1'b0;
      r_sel1 <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_v1   <= w_fire;
      r_sel1 <= w_grant_idx;
      r_v2   <= r_v1;
    end
  end

  // capture the popped word one cycle after its pop; hold it otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (w_sync_clr) begin
      r_data_out <= '0;
    end else if (r_v1) begin
      r_data_out <= w_data[r_sel1];
    end
  end

  // idle: nothing queued and no pop in the pop/capture stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= 1'b1;
    end else if (w_sync_clr) begin
      r_idle <= 1'b1;
    end else begin
      r_idle <= (&w_empty) & ~w_fire & ~r_v1;
    end
  end

endmodule
